// File: rtl/serial_pkg.sv
// Shared constants and tx state encoding for the 16-bit serial link.
package serial_pkg;

    localparam int DEF_BIT_CLOCKS = 8;
    localparam int DEF_DATA_BITS  = 16;
    localparam int FRAME_CLOCKS   = DEF_BIT_CLOCKS * (DEF_DATA_BITS + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serial_transmit_if.sv
// Parallel-side handshake plus line/status signals of the serial transmitter.
interface serial_transmit_if #(
    parameter int DATA_BITS = 16
);
    logic                 Load;
    logic [DATA_BITS-1:0] DataIn;
    logic                 Ready;
    logic                 Transmit;
    logic                 Busy;
    logic                 Done;

    modport master (output Load, DataIn, input Ready, Transmit, Busy, Done);
    modport slave  (input Load, DataIn, output Ready, Transmit, Busy, Done);
endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous input FIFO with fall-through read data; DEPTH must be a power of 2.
module serial_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            // push and pop together leave the occupancy unchanged
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/serial_transmit.sv
// Frame transmitter: start bit, DATA_BITS LSB first, stop bit, BIT_CLOCKS clocks per bit.
// Define SERIAL_TX_FIFO_EN to buffer words in a FIFO_DEPTH-entry input FIFO.
module serial_transmit
    import serial_pkg::*;
#(
    parameter int BIT_CLOCKS = DEF_BIT_CLOCKS,
    parameter int DATA_BITS  = DEF_DATA_BITS
`ifdef SERIAL_TX_FIFO_EN
    ,
    parameter int FIFO_DEPTH = 4
`endif
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Load,
    input  logic [DATA_BITS-1:0] DataIn,
    output logic                 Ready,
    output logic                 Transmit,
    output logic                 Busy,
    output logic                 Done
);
    localparam int CW = $clog2(BIT_CLOCKS);
    localparam int IW = $clog2(DATA_BITS);

    tx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q, busy_q, done_q;

    logic                 pending, take, bit_end, last_bit;
    logic [DATA_BITS-1:0] next_word;

    assign bit_end  = (cnt_q == CW'(BIT_CLOCKS - 1));
    assign last_bit = (idx_q == IW'(DATA_BITS - 1));
    assign take     = pending && ((state_q == IDLE) || (state_q == STOP && bit_end));

`ifdef SERIAL_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .Clock  (Clock),
        .ResetN (ResetN),
        .push   (Load),
        .pop    (take),
        .din    (DataIn),
        .dout   (next_word),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign Ready   = !fifo_full;
    assign pending = !fifo_empty;
`else
    // Ready is low outside IDLE, so a pending word can only start from IDLE
    assign Ready     = (state_q == IDLE);
    assign pending   = Load && Ready;
    assign next_word = DataIn;
`endif

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // line outputs are registered from the current state, one clock behind it
            tx_q   <= (state_q == START) ? 1'b0 :
                      (state_q == DATA)  ? shift_q[0] : 1'b1;
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == STOP) && bit_end;

            if (state_q == IDLE || bit_end) cnt_q <= '0;
            else                            cnt_q <= cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (take) begin
                        shift_q <= next_word;
                        idx_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) state_q <= DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 1'b1;
                        if (last_bit) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (take) begin
                            shift_q <= next_word;
                            idx_q   <= '0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Transmit = tx_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
endmodule
